// File: rtl/cdb_arbiter_if.sv
// Result request/grant and common-data-bus broadcast signals shared by the arbiter,
// the reservation stations and the broadcast consumers.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_RS   = 8,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned TAG_LEN  = 4
);
  logic [NUM_RS-1:0]          res_valid;
  logic [NUM_RS*DATA_WID-1:0] res_data;
  logic [NUM_RS-1:0]          res_ack;
  logic                       cdb_valid;
  logic [TAG_LEN-1:0]         cdb_tag;
  logic [DATA_WID-1:0]        cdb_data;
  logic                       cdb_ready;
  logic [NUM_RS-1:0]          rs_done;

  modport master (
    output res_valid, res_data, cdb_ready,
    input  res_ack, cdb_valid, cdb_tag, cdb_data, rs_done
  );

  modport slave (
    input  res_valid, res_data, cdb_ready,
    output res_ack, cdb_valid, cdb_tag, cdb_data, rs_done
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one finished reservation station
// per free bus slot, registers its {valid, tag, data} broadcast and pulses rs_done on acceptance.
module cdb_arbiter #(
  parameter int unsigned NUM_RS   = 8,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned TAG_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [TAG_LEN-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WID-1:0] cdb_data_q, cdb_data_d;
  logic [NUM_RS-1:0]   rs_done_q, rs_done_d;

  logic                load_en_c;
  logic                found_c;
  logic [PTR_W-1:0]    gnt_c;
  logic [DATA_WID-1:0] gnt_data_c;
  logic [NUM_RS-1:0]   ack_c;

  // First requester at or after rr_ptr, wrapping modulo NUM_RS
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_c = 1'b0;
    gnt_c   = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_RS;
      if (!found_c && bus.res_valid[PTR_W'(idx)]) begin
        found_c = 1'b1;
        gnt_c   = PTR_W'(idx);
      end
    end
  end

  // Constant-index mux keeps the data select free of variable part-selects
  always_comb begin
    gnt_data_c = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (gnt_c == PTR_W'(i)) begin
        gnt_data_c = bus.res_data[i*DATA_WID +: DATA_WID];
      end
    end
  end

  assign load_en_c = !cdb_valid_q || bus.cdb_ready;

  always_comb begin
    ack_c = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      ack_c[i] = !rst && load_en_c && found_c && (gnt_c == PTR_W'(i));
    end
  end

  // Next-state: load on a free/accepted slot, otherwise hold the stalled broadcast
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    rs_done_d   = '0;

    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rs_done_d[i] = cdb_valid_q && bus.cdb_ready && (cdb_tag_q == TAG_LEN'(i + 1));
    end

    if (load_en_c) begin
      if (found_c) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = TAG_LEN'(gnt_c) + TAG_LEN'(1);
        cdb_data_d  = gnt_data_c;
        rr_ptr_d    = (gnt_c == PTR_W'(NUM_RS - 1)) ? '0 : PTR_W'(gnt_c + PTR_W'(1));
      end else begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      rs_done_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      rs_done_q   <= rs_done_d;
    end
  end

  assign bus.res_ack   = ack_c;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.rs_done   = rs_done_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter: directed cases with fixed expectations plus a random
// run compared against a cycle-level reference model of the round-robin bus.
module tb_cdb_arbiter;
  localparam int unsigned NUM_RS   = 8;
  localparam int unsigned DATA_WID = 16;
  localparam int unsigned TAG_LEN  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_RS(NUM_RS), .DATA_WID(DATA_WID), .TAG_LEN(TAG_LEN)) bus ();

  cdb_arbiter #(.NUM_RS(NUM_RS), .DATA_WID(DATA_WID), .TAG_LEN(TAG_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the broadcast register and rotating priority
  int          m_ptr;
  bit          m_valid;
  int          m_tag;
  logic [15:0] m_data;
  logic [7:0]  m_done;
  logic [7:0]  obs_ack, exp_ack;

  function automatic int pick(input logic [7:0] v, input int ptr);
    for (int k = 0; k < 8; k++) begin
      if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic tick();
    int g;
    logic [7:0]   rv_s;
    logic [127:0] rd_s;
    logic         rdy_s, rst_s;
    @(negedge clk);
    rv_s  = bus.res_valid;
    rd_s  = bus.res_data;
    rdy_s = bus.cdb_ready;
    rst_s = rst;
    g = pick(rv_s, m_ptr);
    exp_ack = 8'h00;
    if (!rst_s && (!m_valid || rdy_s) && g >= 0) exp_ack[g] = 1'b1;
    obs_ack = bus.res_ack;
    @(posedge clk);
    if (rst_s) begin
      m_ptr = 0; m_valid = 0; m_tag = 0; m_data = 16'h0; m_done = 8'h00;
    end else begin
      m_done = 8'h00;
      if (m_valid && rdy_s) m_done[m_tag - 1] = 1'b1;
      if (!m_valid || rdy_s) begin
        if (g >= 0) begin
          m_valid = 1; m_tag = g + 1; m_data = rd_s[g*16 +: 16]; m_ptr = (g + 1) % 8;
        end else begin
          m_valid = 0; m_tag = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.res_valid = 8'h00;
    bus.cdb_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Protocol monitor on the DUT side of the bus
  always @(negedge clk) begin
    n_tests++;
    if (!$onehot0(bus.res_ack)) begin
      n_fail++;
      $display("FAIL ack_onehot0: res_ack=%h", bus.res_ack);
    end
    if (bus.cdb_valid) begin
      n_tests++;
      if (bus.cdb_tag < 4'd1 || bus.cdb_tag > 4'd8) begin
        n_fail++;
        $display("FAIL tag_range: cdb_tag=%0d required 1..8", bus.cdb_tag);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.res_valid = 8'($urandom);
      bus.res_data  = {4{$urandom}};
      bus.cdb_ready = 1'($urandom);
      tick();
      n_tests++;
      if (obs_ack !== 8'h00) begin
        n_fail++; $display("FAIL reset_ack: got %h required 00", obs_ack);
      end
      n_tests++;
      if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 4'd0 || bus.cdb_data !== 16'h0 || bus.rs_done !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs: valid=%b tag=%0d data=%h done=%h required 0/0/0000/00",
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rs_done);
      end
    end
    rst = 1'b0;
    bus.res_valid = 8'h00;
    bus.cdb_ready = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.res_data = {4{$urandom}};
    bus.res_data[2*16 +: 16] = 16'h1234;
    bus.res_valid = 8'h04;
    bus.cdb_ready = 1'b1;
    tick();
    n_tests++;
    if (obs_ack !== 8'h04) begin n_fail++; $display("FAIL single_ack: got %h required 04", obs_ack); end
    bus.res_valid = 8'h00;
    n_tests++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_data !== 16'h1234 || bus.rs_done !== 8'h00) begin
      n_fail++;
      $display("FAIL single_bus: valid=%b tag=%0d data=%h done=%h required 1/3/1234/00",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rs_done);
    end
    tick();
    n_tests++;
    if (bus.rs_done !== 8'h04 || bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL single_done: done=%h valid=%b tag=%0d required 04/0/0",
               bus.rs_done, bus.cdb_valid, bus.cdb_tag);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] want;
    do_reset();
    bus.res_valid = 8'hFF;
    bus.cdb_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.res_data = {4{$urandom}};
      want = bus.res_data[(k % 8)*16 +: 16];
      tick();
      n_tests++;
      if (obs_ack !== 8'(1 << (k % 8))) begin
        n_fail++; $display("FAIL rr_ack[%0d]: got %h required %h", k, obs_ack, 8'(1 << (k % 8)));
      end
      n_tests++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'((k % 8) + 1) || bus.cdb_data !== want) begin
        n_fail++;
        $display("FAIL rr_bus[%0d]: tag=%0d data=%h required %0d/%h", k, bus.cdb_tag, bus.cdb_data, (k % 8) + 1, want);
      end
    end
    bus.res_valid = 8'h00;
  endtask

  task automatic test_stall();
    do_reset();
    bus.res_data[0*16 +: 16] = 16'hA5A5;
    bus.res_valid = 8'h01;
    bus.cdb_ready = 1'b1;
    tick();
    bus.res_data[1*16 +: 16] = 16'h5A5A;
    bus.res_valid = 8'h02;
    bus.cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (obs_ack !== 8'h00 || bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd1 ||
          bus.cdb_data !== 16'hA5A5 || bus.rs_done !== 8'h00) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: ack=%h valid=%b tag=%0d data=%h done=%h required 00/1/1/a5a5/00",
                 c, obs_ack, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rs_done);
      end
    end
    bus.cdb_ready = 1'b1;
    tick();
    bus.res_valid = 8'h00;
    n_tests++;
    if (obs_ack !== 8'h02) begin n_fail++; $display("FAIL stall_release_ack: got %h required 02", obs_ack); end
    n_tests++;
    if (bus.cdb_tag !== 4'd2 || bus.cdb_data !== 16'h5A5A || bus.rs_done !== 8'h01) begin
      n_fail++;
      $display("FAIL stall_release_bus: tag=%0d data=%h done=%h required 2/5a5a/01",
               bus.cdb_tag, bus.cdb_data, bus.rs_done);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.cdb_ready = 1'b1;
    bus.res_valid = 8'h40;
    tick();
    n_tests++;
    if (obs_ack !== 8'h40 || bus.cdb_tag !== 4'd7) begin
      n_fail++; $display("FAIL wrap_setup: ack=%h tag=%0d required 40/7", obs_ack, bus.cdb_tag);
    end
    bus.res_valid = 8'h81;
    tick();
    n_tests++;
    if (obs_ack !== 8'h80 || bus.cdb_tag !== 4'd8 || bus.rs_done !== 8'h40) begin
      n_fail++;
      $display("FAIL wrap_first: ack=%h tag=%0d done=%h required 80/8/40", obs_ack, bus.cdb_tag, bus.rs_done);
    end
    bus.res_valid = 8'h01;
    tick();
    n_tests++;
    if (obs_ack !== 8'h01 || bus.cdb_tag !== 4'd1 || bus.rs_done !== 8'h80) begin
      n_fail++;
      $display("FAIL wrap_second: ack=%h tag=%0d done=%h required 01/1/80", obs_ack, bus.cdb_tag, bus.rs_done);
    end
    bus.res_valid = 8'h00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.res_data[4*16 +: 16] = 16'hBEEF;
    bus.res_valid = 8'h10;
    bus.cdb_ready = 1'b1;
    tick();
    n_tests++;
    if (obs_ack !== 8'h10 || bus.cdb_tag !== 4'd5) begin
      n_fail++; $display("FAIL midrst_setup: ack=%h tag=%0d required 10/5", obs_ack, bus.cdb_tag);
    end
    bus.res_data[4*16 +: 16] = 16'hCAFE;
    bus.cdb_ready = 1'b0;
    tick();
    n_tests++;
    if (obs_ack !== 8'h00 || bus.cdb_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL midrst_stall: ack=%h data=%h required 00/beef", obs_ack, bus.cdb_data);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (obs_ack !== 8'h00 || bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 4'd0 || bus.rs_done !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_flush: ack=%h valid=%b tag=%0d done=%h required 00/0/0/00",
               obs_ack, bus.cdb_valid, bus.cdb_tag, bus.rs_done);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs_ack !== 8'h10 || bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd5 ||
        bus.cdb_data !== 16'hCAFE || bus.rs_done !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_regrant: ack=%h valid=%b tag=%0d data=%h done=%h required 10/1/5/cafe/00",
               obs_ack, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rs_done);
    end
    bus.res_valid = 8'h00;
    bus.cdb_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.rs_done !== 8'h10) begin
      n_fail++; $display("FAIL midrst_done: done=%h required 10", bus.rs_done);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    do_reset();
    bus.res_valid = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      bus.cdb_ready = ($urandom % 10) < 7;
      rst = ($urandom % 150) == 0;
      tick();
      n_tests++;
      if (obs_ack !== exp_ack) begin
        n_fail++; $display("FAIL rand_ack[%0d]: got %h required %h", c, obs_ack, exp_ack);
      end
      n_tests++;
      if (bus.cdb_valid !== 1'(m_valid) || bus.cdb_tag !== 4'(m_tag) ||
          bus.cdb_data !== m_data || bus.rs_done !== m_done) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: valid=%b tag=%0d data=%h done=%h required %b/%0d/%h/%h",
                 c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.rs_done, m_valid, m_tag, m_data, m_done);
      end
      v = bus.res_valid;
      for (int i = 0; i < 8; i++) begin
        if (obs_ack[i]) begin
          if ($urandom % 2 == 0) v[i] = 1'b0;
          else bus.res_data[i*16 +: 16] = 16'($urandom);
        end else if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1'b1;
          bus.res_data[i*16 +: 16] = 16'($urandom);
        end
      end
      bus.res_valid = v;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.res_valid = 8'h00;
    bus.res_data  = '0;
    bus.cdb_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
